dfm_measure: RTL and testbench

//  Reciprocal frequency/duty measurement engine of the DFM. Consumes gate time

---
 rtl/dfm_measure.sv | 192 +++++++++++++++++++
 tb/tb_dfm_measure.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfm_measure.sv
// -----------------------------------------------------------------------------
// dfm_measure
// Reciprocal frequency / duty measurement engine. A gate of reg_gate_time_i
// clk_i cycles is opened on a rising edge of sig_i and closed on the first
// rising edge after the gate time has elapsed. The result
// {high-time, edge count, ref count} goes to the register file through its
// 96-bit result write port.
//
// Ports
//   clk_i            in   1   reference clock, count time base
//   rst_n_i          in   1   asynchronous active-low reset
//   en_i             in   1   1 = measure continuously, 0 = abort / idle
//   sig_i            in   1   signal under test, asynchronous to clk_i
//   reg_gate_time_i  in   32  gate time in clk_i cycles (0 treated as 1)
//   res_wr_en_o      out  1   one-cycle result write strobe
//   res_wr_addr_o    out  3   constant 3'b100 (96-bit result write)
//   res_wr_data_o    out  96  [31:0] ref_cnt, [63:32] sig_cnt, [95:64] pwm_cnt
//   busy_o           out  1   1 while the engine is not idle
//   timeout_o        out  1   qualifies res_wr_en_o as a timeout result
// -----------------------------------------------------------------------------
module dfm_measure #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        sig_i,
    input  logic [31:0] reg_gate_time_i,
    output logic        res_wr_en_o,
    output logic [2:0]  res_wr_addr_o,
    output logic [95:0] res_wr_data_o,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_GATE  = 3'd2,
        S_CLOSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    state_t      state_q, state_d;
    logic        sync1_q, sig_s_q, sig_dly_q;
    logic [31:0] tmr_q, tmr_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [31:0] ref_q, ref_d;
    logic [31:0] sigc_q, sigc_d;
    logic [31:0] pwm_q, pwm_d;
    logic        wr_en_q, wr_en_d;
    logic [95:0] wr_data_q, wr_data_d;
    logic        busy_q;
    logic        timeout_q, timeout_d;
    logic        rise_s;
    logic [31:0] gate_len_s;

    assign rise_s     = sig_s_q & ~sig_dly_q;
    assign gate_len_s = (reg_gate_time_i == 32'd0) ? 32'd1 : reg_gate_time_i;

    // Two-flop synchronizer plus delay stage for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q   <= 1'b0;
            sig_s_q   <= 1'b0;
            sig_dly_q <= 1'b0;
        end else begin
            sync1_q   <= sig_i;
            sig_s_q   <= sync1_q;
            sig_dly_q <= sig_s_q;
        end
    end

    // Next-state, counter and result logic.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        to_cnt_d  = to_cnt_q;
        ref_d     = ref_q;
        sigc_d    = sigc_q;
        pwm_d     = pwm_q;
        wr_en_d   = 1'b0;
        wr_data_d = 96'd0;
        timeout_d = 1'b0;
        if (!en_i) begin
            // Abort: counters are left as they are until the next gate opens.
            state_d  = S_IDLE;
            to_cnt_d = 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_ARM;
                    to_cnt_d = 32'd0;
                end
                S_ARM: begin
                    if (rise_s) begin
                        state_d = S_GATE;
                        ref_d   = 32'd0;
                        sigc_d  = 32'd0;
                        pwm_d   = 32'd0;
                        tmr_d   = gate_len_s - 32'd1;
                    end else if (to_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                        state_d   = S_DONE;
                        wr_en_d   = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 32'd1;
                    end
                end
                S_GATE: begin
                    ref_d  = sat_inc(ref_q);
                    pwm_d  = sig_s_q ? sat_inc(pwm_q) : pwm_q;
                    sigc_d = rise_s ? sat_inc(sigc_q) : sigc_q;
                    // A rise in the final gate cycle is counted but never closes.
                    if (tmr_q == 32'd0) begin
                        state_d  = S_CLOSE;
                        to_cnt_d = 32'd0;
                    end else begin
                        tmr_d = tmr_q - 32'd1;
                    end
                end
                S_CLOSE: begin
                    ref_d  = sat_inc(ref_q);
                    pwm_d  = sig_s_q ? sat_inc(pwm_q) : pwm_q;
                    sigc_d = rise_s ? sat_inc(sigc_q) : sigc_q;
                    if (rise_s) begin
                        state_d   = S_DONE;
                        wr_en_d   = 1'b1;
                        wr_data_d = {pwm_d, sigc_d, ref_d};
                    end else if (to_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                        state_d   = S_DONE;
                        wr_en_d   = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 32'd1;
                    end
                end
                S_DONE: begin
                    // DONE lasts one cycle, so strobes can never be adjacent.
                    state_d  = S_ARM;
                    to_cnt_d = 32'd0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            tmr_q     <= 32'd0;
            to_cnt_q  <= 32'd0;
            ref_q     <= 32'd0;
            sigc_q    <= 32'd0;
            pwm_q     <= 32'd0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 96'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            to_cnt_q  <= to_cnt_d;
            ref_q     <= ref_d;
            sigc_q    <= sigc_d;
            pwm_q     <= pwm_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            busy_q    <= (state_d != S_IDLE);
            timeout_q <= timeout_d;
        end
    end

    assign res_wr_en_o   = wr_en_q;
    assign res_wr_addr_o = 3'b100;
    assign res_wr_data_o = wr_data_q;
    assign busy_o        = busy_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_dfm_measure.sv
module tb_dfm_measure;

    localparam logic [31:0] TO = 32'd500;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        en_i = 1'b0;
    logic        sig_i = 1'b0;
    logic [31:0] reg_gate_time_i = 32'd0;
    logic        res_wr_en_o;
    logic [2:0]  res_wr_addr_o;
    logic [95:0] res_wr_data_o;
    logic        busy_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    logic prev_wr = 1'b0;
    logic [96:0] exp_q[$];

    int sig_per = 100;
    int sig_hi  = 50;
    bit sig_run = 1'b0;

    dfm_measure #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .sig_i(sig_i),
        .reg_gate_time_i(reg_gate_time_i), .res_wr_en_o(res_wr_en_o),
        .res_wr_addr_o(res_wr_addr_o), .res_wr_data_o(res_wr_data_o),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Square wave of sig_per clocks, sig_hi clocks high, edges 2 ns before posedge.
    initial begin
        #3;
        forever begin
            if (sig_run) begin
                sig_i = 1'b1;
                #(sig_hi * 10);
                sig_i = 1'b0;
                #((sig_per - sig_hi) * 10);
            end else begin
                sig_i = 1'b0;
                #10;
            end
        end
    end

    // Expected result: close rise is the first one strictly after the gate.
    function automatic logic [96:0] exp_meas(input int g, input int p, input int h);
        int ge;
        int k;
        ge = (g < 1) ? 1 : g;
        k  = ge / p + 1;
        return {1'b0, 32'(k * h), 32'(k), 32'(k * p)};
    endfunction

    // Scoreboard: every strobe pops one expected {timeout, data}.
    always @(negedge clk_i) begin
        logic [96:0] e;
        if (!rst_n_i) begin
            prev_wr = 1'b0;
        end else begin
            if (!res_wr_en_o && timeout_o) begin
                errors++;
                $display("FAIL timeout_idle got 1 want 0");
            end
            if (res_wr_en_o) begin
                n_wr++;
                checks++;
                if (prev_wr) begin
                    errors++;
                    $display("FAIL wr_adjacent got two strobes in a row want one");
                end
                checks++;
                if (res_wr_addr_o !== 3'b100) begin
                    errors++;
                    $display("FAIL wr_addr got %b want 100", res_wr_addr_o);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got data %h", res_wr_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({timeout_o, res_wr_data_o} !== e) begin
                        errors++;
                        $display("FAIL result got to=%b pwm=%0d sig=%0d ref=%0d want to=%b pwm=%0d sig=%0d ref=%0d",
                                 timeout_o, res_wr_data_o[95:64], res_wr_data_o[63:32], res_wr_data_o[31:0],
                                 e[96], e[95:64], e[63:32], e[31:0]);
                    end
                end
            end
            prev_wr = res_wr_en_o;
        end
    end

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge clk_i);
            c++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d results outstanding want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_wr(output int lat);
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!res_wr_en_o && lat < 3000);
        checks++;
        if (!res_wr_en_o) begin
            errors++;
            $display("FAIL wait_wr got no strobe want one within 3000 cycles");
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s got busy=%b want 0", name, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({res_wr_en_o, res_wr_addr_o, res_wr_data_o, busy_o, timeout_o} !== {1'b0, 3'b100, 96'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset got en=%b addr=%b data=%h busy=%b to=%b want 0 100 0 0 0",
                     res_wr_en_o, res_wr_addr_o, res_wr_data_o, busy_o, timeout_o);
        end
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_measure(input int g, input int p, input int h);
        sig_per = p;
        sig_hi  = h;
        sig_run = 1'b1;
        reg_gate_time_i = 32'(g);
        repeat (300) @(negedge clk_i);
        exp_q.push_back(exp_meas(g, p, h));
        en_i = 1'b1;
        wait_drain(5000);
        en_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_idle("measure_idle");
    endtask

    task automatic test_timeout();
        int lat;
        int c;
        sig_run = 1'b0;
        reg_gate_time_i = 32'd100;
        repeat (20) @(negedge clk_i);
        exp_q.push_back({1'b1, 96'd0});
        exp_q.push_back({1'b1, 96'd0});
        en_i = 1'b1;
        c = 0;
        while (!busy_o && c < 10) begin
            @(negedge clk_i);
            c++;
        end
        // Counter reaches 499 in cycle ARM+499; the strobe is registered one later.
        wait_wr(lat);
        checks++;
        if (lat != 500) begin
            errors++;
            $display("FAIL timeout_latency got %0d want 500", lat);
        end
        // Re-arm takes one DONE cycle before the next 500-cycle wait.
        wait_wr(lat);
        checks++;
        if (lat != 501) begin
            errors++;
            $display("FAIL timeout_rearm got %0d want 501", lat);
        end
        en_i = 1'b0;
        wait_drain(10);
        repeat (2) @(negedge clk_i);
        check_idle("timeout_idle");
    endtask

    task automatic test_abort();
        int n0;
        sig_per = 100;
        sig_hi  = 50;
        sig_run = 1'b1;
        reg_gate_time_i = 32'd1050;
        repeat (300) @(negedge clk_i);
        en_i = 1'b1;
        repeat (300) @(negedge clk_i);
        n0 = n_wr;
        en_i = 1'b0;
        @(negedge clk_i);
        check_idle("abort_busy");
        repeat (1200) @(negedge clk_i);
        checks++;
        if (n_wr != n0) begin
            errors++;
            $display("FAIL abort_nowrite got %0d writes want 0", n_wr - n0);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        sig_per = 50;
        sig_hi  = 25;
        sig_run = 1'b1;
        reg_gate_time_i = 32'd200;
        repeat (300) @(negedge clk_i);
        exp_q.push_back(exp_meas(200, 50, 25));
        exp_q.push_back(exp_meas(200, 50, 25));
        exp_q.push_back(exp_meas(120, 50, 25));
        en_i = 1'b1;
        wait_wr(lat);
        // Change lands in the middle of the second gate; only the third sees it.
        repeat (100) @(negedge clk_i);
        reg_gate_time_i = 32'd120;
        wait_wr(lat);
        checks++;
        if (lat != 200) begin
            errors++;
            $display("FAIL b2b_spacing1 got %0d want 300", lat + 100);
        end
        wait_wr(lat);
        checks++;
        if (lat != 200) begin
            errors++;
            $display("FAIL b2b_spacing2 got %0d want 200", lat);
        end
        en_i = 1'b0;
        wait_drain(10);
        repeat (2) @(negedge clk_i);
        check_idle("b2b_idle");
    endtask

    task automatic test_reset_mid();
        int n0;
        reg_gate_time_i = 32'd1050;
        sig_per = 100;
        sig_hi  = 50;
        en_i = 1'b1;
        repeat (300) @(negedge clk_i);
        n0 = n_wr;
        rst_n_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({res_wr_en_o, res_wr_data_o, busy_o, timeout_o} !== {1'b0, 96'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got en=%b data=%h busy=%b to=%b want all 0",
                     res_wr_en_o, res_wr_data_o, busy_o, timeout_o);
        end
        en_i = 1'b0;
        rst_n_i = 1'b1;
        repeat (1200) @(negedge clk_i);
        checks++;
        if (n_wr != n0) begin
            errors++;
            $display("FAIL reset_mid_nowrite got %0d writes want 0", n_wr - n0);
        end
    endtask

    initial begin
        test_reset();
        test_measure(1050, 100, 50);
        test_measure(1000, 100, 50);
        test_measure(0, 40, 10);
        test_timeout();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
